instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter PC_W, default 8, width of the program counter.
REQ-002 Parameter INSTR_W, default 20, instruction width.
REQ-003 Parameter END_PC, default 20, first address past the last valid program word.
REQ-004 There SHALL be one clock and one reset. Reset SHALL be asynchronous and active-high. The ports are listed below.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 pc  output  PC_W  address to the combinational instruction memory.
REQ-008 instruction  input  INSTR_W  memory read data, valid in the same cycle as pc.
REQ-009 out_valid  output  1  the IF/ID register holds an instruction.
REQ-010 out_ready  input  1  decode accepts out_instr this cycle.
REQ-011 out_instr  output  INSTR_W  fetched instruction.
REQ-012 out_pc  output  PC_W  address out_instr was fetched from.
REQ-013 redirect_valid  input  1  branch or jump redirect from execute.
REQ-014 redirect_pc  input  PC_W  redirect target.
REQ-015 halted  output  1  the fetch FSM is in HALT.
REQ-016 fetch_count  output  16  count of instructions loaded into IF/ID.

Function
REQ-017 The FSM SHALL have two states, FETCH and HALT.
REQ-018 pc SHALL be driven directly from the internal PC register.
REQ-019 A load SHALL occur when all of the following hold: state=FETCH, (!out_valid || out_ready), !redirect_valid.
- REQ-020 On a load: out_instr<=instruction, out_pc<=pc, out_valid<=1, pc<=next_pc, fetch_count<=fetch_count+1.
- REQ-021 fetch_count SHALL wrap from 0xFFFF to 0.
REQ-022 next_pc SHALL be pc+1 modulo 2^PC_W, so 255 wraps to 0.
REQ-023 The opcode field is instruction[19:15]; the jump opcode is 5'b01001; the jump target is instruction[7:0].
REQ-024 Stall: when out_valid=1 and out_ready=0, out_instr, out_pc, out_valid and pc SHALL hold.
REQ-025 When out_ready=1 and no load occurs, out_valid SHALL go to 0 on the next edge.
REQ-026 Handoff SHALL be one per clock: back-to-back loads with out_ready held high give one instruction per cycle.
REQ-027 Fetch latency SHALL be 1 cycle from pc to out_instr.
REQ-028 redirect_valid SHALL have highest priority. On a redirect:
- pc<=redirect_pc
- out_valid<=0 (flush the IF/ID entry even if stalled)
- state<=FETCH
- no load that cycle, and fetch_count unchanged.
REQ-029 FETCH->HALT SHALL occur when a load leaves next_pc >= END_PC, or when pc >= END_PC with no load pending. After that, no further loads occur.
REQ-030 In HALT, out_valid SHALL drain normally via out_ready, and the unit SHALL stay in HALT until a redirect.
REQ-031 halted SHALL be 1 exactly when state=HALT.
REQ-032 When redirect_valid and the halt condition occur in the same cycle, the redirect SHALL win.

Reset
REQ-033 While rst=1, regardless of clk: pc=0, out_valid=0, out_instr=0, out_pc=0, fetch_count=0, state=FETCH, halted=0.
REQ-034 rst asserted mid-stall or mid-redirect SHALL discard the pending instruction.
REQ-035 The first load SHALL occur on the first rising edge after rst deasserts, fetching address 0.

Configuration
REQ-036 The macro FETCH_JUMP_PREDECODE_EN SHALL control jump predecode.
- REQ-037 When defined: on a load whose instruction opcode equals the jump opcode, next_pc SHALL be instruction[7:0] instead of pc+1. The jump is still delivered to decode. The END_PC check SHALL use this target.
- REQ-038 When undefined: next_pc is always pc+1, and jumps resolve only via redirect.

Structure
REQ-039 Package fetch_pkg SHALL hold:
- PC_W and INSTR_W defaults
- the OPCODE_MSB/OPCODE_LSB field positions (19/15)
- OPCODE_JUMP = 5'b01001
- the jump target field positions (7/0)
- the fetch FSM state enum.
REQ-040 One sub-module, fetch_pc_next, SHALL compute next_pc: increment, optional jump predecode, wrap.

Verification
REQ-041 Reset, then out_ready held 1 with the 20-word program -> out_pc = 0,1,2,...,19 on consecutive cycles; halted=1 after 19 is loaded; fetch_count=20.
REQ-042 out_ready=0 for 3 cycles while out_pc=5 -> out_instr/out_pc/pc frozen and fetch_count constant; release -> out_pc=6 on the next cycle.
REQ-043 redirect_valid=1, redirect_pc=3 while stalled at out_pc=10 -> next cycle out_valid=0 and pc=3; the cycle after, out_pc=3.
REQ-044 In HALT with redirect_pc=0 -> halted=0, and fetching resumes from 0.
REQ-045 FETCH_JUMP_PREDECODE_EN defined, instruction 20'b01001000000000000011 at pc=19 -> next pc=3 and the jump is still presented at out_pc=19. Macro undefined -> the unit halts.
REQ-046 pc wrap: END_PC=256, pc=255 loaded -> next pc=0, no halt.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - default program-counter and instruction widths
//   - opcode field position and the jump opcode value
//   - jump target field position
//   - fetch FSM state encoding
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_W_DEFAULT    = 8;
    localparam int INSTR_W_DEFAULT = 20;

    // Opcode field inside an instruction word.
    localparam int OPCODE_MSB = 19;
    localparam int OPCODE_LSB = 15;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_W-1:0] OPCODE_JUMP = 5'b01001;

    // Absolute jump target field inside a jump instruction.
    localparam int JUMP_TGT_MSB = 7;
    localparam int JUMP_TGT_LSB = 0;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_pc_next.sv
// -----------------------------------------------------------------------------
// fetch_pc_next
// Computes the address fetched after the current one: pc+1 modulo 2^PC_W,
// or, when jump predecode is compiled in, the absolute target of a jump
// instruction sitting at the current pc.
//
// Configuration macro: FETCH_JUMP_PREDECODE_EN
//   defined   -> jump opcode at pc selects instruction[7:0] as next address
//   undefined -> next address is always pc+1
//
// Ports:
//   pc_i          current program counter
//   instruction_i instruction word read from pc_i
//   next_pc_o     address to fetch after pc_i
// -----------------------------------------------------------------------------
module fetch_pc_next
    import fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic [PC_W-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instruction_i,
    output logic [PC_W-1:0]    next_pc_o
);

    logic [PC_W-1:0] pc_inc;

    // The adder result is truncated to PC_W bits, so the top address wraps to 0.
    assign pc_inc = pc_i + PC_W'(1);

`ifdef FETCH_JUMP_PREDECODE_EN
    logic            is_jump;
    logic [PC_W-1:0] jump_target;

    assign is_jump     = (instruction_i[OPCODE_MSB:OPCODE_LSB] == OPCODE_JUMP);
    assign jump_target = PC_W'(instruction_i[JUMP_TGT_MSB:JUMP_TGT_LSB]);
    assign next_pc_o   = is_jump ? jump_target : pc_inc;
`else
    // Jumps are left to the execute stage, which steers fetch via redirect.
    assign next_pc_o = pc_inc;
`endif

    // Only a few instruction bits matter here (none without predecode).
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction_i;

endmodule : fetch_pc_next

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Single-entry fetch stage. Drives the address of a combinational
// instruction memory, captures the returned word into the IF/ID register
// with a valid/ready handshake towards decode, accepts redirects from
// execute, and halts once the program end address is reached.
//
// Configuration macro: FETCH_JUMP_PREDECODE_EN (see fetch_pc_next).
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset
//   pc             address to the instruction memory (registered)
//   instruction    memory read data for pc, same cycle
//   out_valid      IF/ID register holds an instruction
//   out_ready      decode accepts out_instr this cycle
//   out_instr      fetched instruction
//   out_pc         address out_instr was fetched from
//   redirect_valid branch/jump redirect from execute (highest priority)
//   redirect_pc    redirect target
//   halted         fetch FSM is in HALT
//   fetch_count    number of instructions loaded into IF/ID (wraps)
// -----------------------------------------------------------------------------
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          PC_W    = PC_W_DEFAULT,
    parameter int          INSTR_W = INSTR_W_DEFAULT,
    parameter int unsigned END_PC  = 20
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_e       state_q,       state_d;
    logic [PC_W-1:0]    pc_q,          pc_d;
    logic               out_valid_q,   out_valid_d;
    logic [INSTR_W-1:0] out_instr_q,   out_instr_d;
    logic [PC_W-1:0]    out_pc_q,      out_pc_d;
    logic [15:0]        fetch_count_q, fetch_count_d;

    logic [PC_W-1:0]    next_pc;
    logic               load;

    fetch_pc_next #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_pc_next (
        .pc_i          (pc_q),
        .instruction_i (instruction),
        .next_pc_o     (next_pc)
    );

    // The IF/ID slot can take a new word when it is empty or being drained
    // this cycle; a redirect always suppresses the load.
    assign load = (state_q == ST_FETCH) && (!out_valid_q || out_ready) && !redirect_valid;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so that no
        // path through the branches below leaves it unassigned (no latches).
        state_d       = state_q;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            // Redirect wins over loads and over the halt condition, and
            // flushes the IF/ID entry even while decode is stalling.
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            state_d     = ST_FETCH;
        end else if (load) begin
            out_instr_d   = instruction;
            out_pc_d      = pc_q;
            out_valid_d   = 1'b1;
            pc_d          = next_pc;
            fetch_count_d = fetch_count_q + 16'd1;
            // Halt as soon as the address just produced lies past the program.
            if (32'(next_pc) >= END_PC) begin
                state_d = ST_HALT;
            end
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            // Covers a pc already past the program (e.g. after a redirect)
            // while decode is stalling.
            if ((state_q == ST_FETCH) && (32'(pc_q) >= END_PC)) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= '0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            fetch_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = fetch_count_q;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit. A combinational instruction
// memory is modelled here; expected IF/ID contents are queued when a fetch
// sequence is started and compared whenever decode accepts a word.
// A second instance with END_PC=256 exercises program-counter wrap.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [19:0] JUMP_TO_3 = 20'b01001000000000000011;

    typedef struct packed {
        logic [7:0]  pc;
        logic [19:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;

    // Main instance (END_PC = 20)
    logic [7:0]  pc;
    logic [19:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_instr;
    logic [7:0]  out_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halted;
    logic [15:0] fetch_count;

    // Wrap instance (END_PC = 256)
    logic [7:0]  w_pc;
    logic [19:0] w_instruction;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [19:0] w_out_instr;
    logic [7:0]  w_out_pc;
    logic        w_redirect_valid;
    logic [7:0]  w_redirect_pc;
    logic        w_halted;
    logic [15:0] w_fetch_count;

    logic [19:0] mem [0:255];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          n;

    assign instruction   = mem[pc];
    assign w_instruction = mem[w_pc];

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .instruction    (instruction),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    instruction_fetch_unit #(.END_PC(256)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .pc             (w_pc),
        .instruction    (w_instruction),
        .out_valid      (w_out_valid),
        .out_ready      (w_out_ready),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .halted         (w_halted),
        .fetch_count    (w_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Non-jump program word: opcode 3, address-dependent payload.
    function automatic logic [19:0] instr_of(input int a);
        return {5'b00011, 7'(a * 3), 8'(a)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        exp_t e;
        for (int a = lo; a <= hi; a++) begin
            e.pc    = 8'(a);
            e.instr = mem[a];
            sb.push_back(e);
        end
    endtask

    // Called at a falling edge with inputs already set for the coming rising
    // edge: scores a handshake if one is about to happen, then advances one cycle.
    task automatic tick();
        exp_t e;
        if (out_valid && out_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_pc", 32'(out_pc), 32'(e.pc));
                check("out_instr", 32'(out_instr), 32'(e.instr));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run until only the last queued word remains, bounded by a cycle budget.
    task automatic drain_to_last(output int cnt);
        cnt = 0;
        while (sb.size() > 1 && cnt < 60) begin
            tick();
            cnt++;
        end
        check("drain_budget", 32'(sb.size()), 32'd1);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = instr_of(a);
        rst              = 1'b0;
        out_ready        = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        w_out_ready      = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;

        // ---- reset values -------------------------------------------------
        #1 rst = 1'b1;
        #1;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'd0);
        check("rst_out_pc", 32'(out_pc), 32'd0);
        check("rst_fetch_count", 32'(fetch_count), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;

        // ---- full program, decode always ready ----------------------------
        push_range(0, 19);
        drain_to_last(n);
        check("stream_cycles", 32'(n), 32'd20);
        check("last_out_pc", 32'(out_pc), 32'd19);
        check("halt_after_19", 32'(halted), 32'd1);
        check("count_20", 32'(fetch_count), 32'd20);
        check("pc_20", 32'(pc), 32'd20);
        tick();
        check("sb_empty_a", 32'(sb.size()), 32'd0);
        check("drained_valid", 32'(out_valid), 32'd0);
        tick();
        check("halt_no_load", 32'(fetch_count), 32'd20);
        check("halt_stays", 32'(halted), 32'd1);

        // ---- redirect out of HALT to 0 ------------------------------------
        redirect_valid = 1'b1;
        redirect_pc    = 8'd0;
        tick();
        redirect_valid = 1'b0;
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_pc", 32'(pc), 32'd0);
        check("resume_valid", 32'(out_valid), 32'd0);

        // ---- stall at out_pc=5 for three cycles ---------------------------
        push_range(0, 19);
        for (int i = 0; i < 6; i++) tick();
        check("pre_stall_out_pc", 32'(out_pc), 32'd5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_out_pc", 32'(out_pc), 32'd5);
            check("stall_out_instr", 32'(out_instr), 32'(instr_of(5)));
            check("stall_pc", 32'(pc), 32'd6);
            check("stall_count", 32'(fetch_count), 32'd26);
        end
        out_ready = 1'b1;
        tick();
        check("release_out_pc", 32'(out_pc), 32'd6);
        check("release_count", 32'(fetch_count), 32'd27);

        // ---- redirect to 3 while stalled at out_pc=10 ---------------------
        for (int i = 0; i < 4; i++) tick();
        check("pre_redir_out_pc", 32'(out_pc), 32'd10);
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'd3;
        sb.delete();
        push_range(3, 19);
        tick();
        check("redir_flush", 32'(out_valid), 32'd0);
        check("redir_pc", 32'(pc), 32'd3);
        check("redir_count", 32'(fetch_count), 32'd31);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        check("redir_out_pc", 32'(out_pc), 32'd3);
        check("redir_valid", 32'(out_valid), 32'd1);
        drain_to_last(n);
        check("redir_last_out_pc", 32'(out_pc), 32'd19);
        check("redir_halted", 32'(halted), 32'd1);
        check("redir_total", 32'(fetch_count), 32'd48);
        tick();
        check("sb_empty_b", 32'(sb.size()), 32'd0);

        // ---- asynchronous reset mid-stall, then first fetch ---------------
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'd0;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("pending_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #2;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_pc", 32'(pc), 32'd0);
        check("async_out_pc", 32'(out_pc), 32'd0);
        check("async_out_instr", 32'(out_instr), 32'd0);
        check("async_count", 32'(fetch_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("first_out_pc", 32'(out_pc), 32'd0);
        check("first_out_instr", 32'(out_instr), 32'(instr_of(0)));
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_count", 32'(fetch_count), 32'd1);

        // ---- jump word at the last program address ------------------------
        redirect_valid = 1'b1;
        redirect_pc    = 8'd17;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        mem[19]        = JUMP_TO_3;
        push_range(17, 19);
        for (int i = 0; i < 3; i++) tick();
        check("jump_out_pc", 32'(out_pc), 32'd19);
        check("jump_out_instr", 32'(out_instr), 32'(JUMP_TO_3));
`ifdef FETCH_JUMP_PREDECODE_EN
        check("jump_next_pc", 32'(pc), 32'd3);
        check("jump_halted", 32'(halted), 32'd0);
`else
        check("jump_next_pc", 32'(pc), 32'd20);
        check("jump_halted", 32'(halted), 32'd1);
`endif
        tick();
        check("sb_empty_c", 32'(sb.size()), 32'd0);
        out_ready = 1'b0;
        mem[19]   = instr_of(19);

        // ---- pc wrap with END_PC=256 --------------------------------------
        w_redirect_valid = 1'b1;
        w_redirect_pc    = 8'd254;
        tick();
        w_redirect_valid = 1'b0;
        check("wrap_redir_pc", 32'(w_pc), 32'd254);
        tick();
        check("wrap_pc_255", 32'(w_pc), 32'd255);
        check("wrap_out_pc_254", 32'(w_out_pc), 32'd254);
        tick();
        check("wrap_pc_0", 32'(w_pc), 32'd0);
        check("wrap_out_pc_255", 32'(w_out_pc), 32'd255);
        check("wrap_no_halt", 32'(w_halted), 32'd0);
        tick();
        check("wrap_out_pc_0", 32'(w_out_pc), 32'd0);
        check("wrap_out_instr_0", 32'(w_out_instr), 32'(instr_of(0)));
        check("wrap_still_running", 32'(w_halted), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
